// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data, redirect request, and
// the {pc, instruction} valid/ready stream towards decode.
interface fetch_unit_if;
  logic [31:0] IMA;
  logic [31:0] IMRD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  // Fetch unit side
  modport master (
    output IMA,
    input  IMRD,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output halted
  );

  // Memory / decode / redirect-source side
  modport slave (
    input  IMA,
    output IMRD,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction memory
// combinationally, and buffers up to two {pc, inst} pairs for decode.
// Entry 0 is always the head, so the outputs come straight from registers
// and keep their last head value when the buffer drains.
module fetch_unit #(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master bus
);

  localparam logic [1:0]  FULL      = 2'(BUF_DEPTH);
  localparam logic [31:0] PC_RESET  = 32'(RESET_PC);
  localparam logic [31:0] PC_LIMIT  = 32'(MEM_DEPTH);

  logic [31:0] pc_reg;
  logic [1:0]  count_reg;
  logic        halted_reg;
  logic [31:0] ent_pc_reg   [2];
  logic [31:0] ent_inst_reg [2];

  logic        pop;
  logic        fetch;
  logic [31:0] pc_next;
  logic [1:0]  wr_idx;

  // Handshake and fetch decisions for this cycle
  always_comb begin
    pop     = (count_reg != 2'd0) & bus.out_ready;
    fetch   = !halted_reg & !bus.redirect_valid & ((count_reg != FULL) | pop);
    pc_next = pc_reg + 32'd1;
    // Tail slot after any pop: 0 when the new word becomes the head, else 1
    wr_idx  = count_reg - {1'b0, pop};
  end

  // PC, halt flag and in-order two-entry buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg     <= PC_RESET;
      count_reg  <= 2'd0;
      halted_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_pc_reg[i]   <= 32'd0;
        ent_inst_reg[i] <= 32'd0;
      end
    end else if (bus.redirect_valid) begin
      // Flush leaves entry contents alone; only the count matters
      pc_reg     <= bus.redirect_pc;
      count_reg  <= 2'd0;
      halted_reg <= (bus.redirect_pc >= PC_LIMIT);
    end else begin
      if (pop && (count_reg == FULL)) begin
        ent_pc_reg[0]   <= ent_pc_reg[1];
        ent_inst_reg[0] <= ent_inst_reg[1];
      end
      if (fetch) begin
        ent_pc_reg[wr_idx[0]]   <= pc_reg;
        ent_inst_reg[wr_idx[0]] <= bus.IMRD;
        pc_reg                  <= pc_next;
        if (pc_next == PC_LIMIT) begin
          halted_reg <= 1'b1;
        end
      end
      count_reg <= count_reg - {1'b0, pop} + {1'b0, fetch};
    end
  end

  // Outputs are plain views of state
  always_comb begin
    bus.IMA       = pc_reg;
    bus.out_valid = (count_reg != 2'd0);
    bus.out_inst  = ent_inst_reg[0];
    bus.out_pc    = ent_pc_reg[0];
    bus.halted    = halted_reg;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word i holds 0x1000_0000 + i.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (0),
    .MEM_DEPTH(32),
    .BUF_DEPTH(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Combinational instruction memory; out-of-range reads return a marker
  assign bus.IMRD = (bus.IMA < 32'd32) ? (32'h1000_0000 + bus.IMA) : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd0) begin bad++; $display("FAIL reset_ima got=%0h want=0", bus.IMA); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", bus.halted); end
    total++; if (bus.out_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0h want=0", bus.out_pc); end
    total++; if (bus.out_inst !== 32'd0) begin bad++; $display("FAIL reset_inst got=%0h want=0", bus.out_inst); end
    $display("reset: valid=%0b ima=%0h halted=%0b", bus.out_valid, bus.IMA, bus.halted);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_pc !== 32'd0) begin bad++; $display("FAIL first_pc got=%0h want=0", bus.out_pc); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 32; i++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, bus.out_valid); end
      total++; if (bus.out_pc !== 32'(i)) begin bad++; $display("FAIL stream_pc[%0d] got=%0h want=%0h", i, bus.out_pc, i); end
      total++; if (bus.out_inst !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL stream_inst[%0d] got=%0h want=%0h", i, bus.out_inst, 32'h1000_0000 + 32'(i)); end
      if (i == 30) begin
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL stream_early_halt got=%0b want=0", bus.halted); end
      end
      if (i == 31) begin
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL stream_halt got=%0b want=1", bus.halted); end
        total++; if (bus.IMA !== 32'd32) begin bad++; $display("FAIL stream_ima_end got=%0h want=20", bus.IMA); end
      end
      $display("stream: pc=%0h inst=%0h", bus.out_pc, bus.out_inst);
      step();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd32) begin bad++; $display("FAIL stream_ima_rest got=%0h want=20", bus.IMA); end
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL stream_halt_hold got=%0b want=1", bus.halted); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.IMA !== 32'd2) begin bad++; $display("FAIL bp_ima[%0d] got=%0h want=2", c, bus.IMA); end
      total++; if (bus.out_pc !== 32'd0) begin bad++; $display("FAIL bp_head[%0d] got=%0h want=0", c, bus.out_pc); end
      $display("backpressure: ima=%0h head=%0h", bus.IMA, bus.out_pc);
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b want=1", k, bus.out_valid); end
      total++; if (bus.out_pc !== 32'(k)) begin bad++; $display("FAIL bp_pc[%0d] got=%0h want=%0h", k, bus.out_pc, k); end
      total++; if (bus.out_inst !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL bp_inst[%0d] got=%0h want=%0h", k, bus.out_inst, 32'h1000_0000 + 32'(k)); end
      $display("release: pc=%0h", bus.out_pc);
      step();
    end
  endtask

  task automatic test_toggle();
    int exp_pc;
    exp_pc = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = ((c % 2) == 0);
      if (bus.out_valid && bus.out_ready) begin
        total++; if (bus.out_pc !== 32'(exp_pc)) begin bad++; $display("FAIL toggle_pc got=%0h want=%0h", bus.out_pc, exp_pc); end
        total++; if (bus.out_inst !== 32'h1000_0000 + 32'(exp_pc)) begin bad++; $display("FAIL toggle_inst got=%0h want=%0h", bus.out_inst, 32'h1000_0000 + 32'(exp_pc)); end
        $display("toggle: delivered pc=%0h", bus.out_pc);
        exp_pc++;
      end
      step();
    end
    total++; if (exp_pc != 7) begin bad++; $display("FAIL toggle_count got=%0d want=7", exp_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    step();
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    total++; if (bus.out_pc !== 32'd3) begin bad++; $display("FAIL redir_head got=%0h want=3", bus.out_pc); end
    total++; if (bus.IMA !== 32'd5) begin bad++; $display("FAIL redir_ima_pre got=%0h want=5", bus.IMA); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd20;
    $display("redirect: delivered pc=%0h with redirect to 14", bus.out_pc);
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd20) begin bad++; $display("FAIL redir_ima got=%0h want=14", bus.IMA); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_pc !== 32'd20) begin bad++; $display("FAIL redir_pc got=%0h want=14", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h1000_0014) begin bad++; $display("FAIL redir_inst got=%0h want=10000014", bus.out_inst); end
    $display("redirect: target pc=%0h inst=%0h", bus.out_pc, bus.out_inst);
    step();
    total++; if (bus.out_pc !== 32'd21) begin bad++; $display("FAIL redir_next got=%0h want=15", bus.out_pc); end
  endtask

  task automatic test_halt_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd30;
    step();
    bus.redirect_valid = 1'b0;
    step();
    total++; if (bus.out_pc !== 32'd30) begin bad++; $display("FAIL hr_pc30 got=%0h want=1e", bus.out_pc); end
    step();
    total++; if (bus.out_pc !== 32'd31) begin bad++; $display("FAIL hr_pc31 got=%0h want=1f", bus.out_pc); end
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL hr_halt got=%0b want=1", bus.halted); end
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hr_idle got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd32) begin bad++; $display("FAIL hr_rest got=%0h want=20", bus.IMA); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd5;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL hr_unhalt got=%0b want=0", bus.halted); end
    total++; if (bus.IMA !== 32'd5) begin bad++; $display("FAIL hr_ima5 got=%0h want=5", bus.IMA); end
    step();
    total++; if (bus.out_pc !== 32'd5) begin bad++; $display("FAIL hr_pc5 got=%0h want=5", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h1000_0005) begin bad++; $display("FAIL hr_inst5 got=%0h want=10000005", bus.out_inst); end
    $display("resume: pc=%0h inst=%0h", bus.out_pc, bus.out_inst);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd40;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL hr_halt40 got=%0b want=1", bus.halted); end
    total++; if (bus.IMA !== 32'd40) begin bad++; $display("FAIL hr_ima40 got=%0h want=28", bus.IMA); end
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hr_idle40 got=%0b want=0", bus.out_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL hr_halt_max got=%0b want=1", bus.halted); end
    step();
    total++; if (bus.IMA !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hr_ima_max got=%0h want=ffffffff", bus.IMA); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hr_idle_max got=%0b want=0", bus.out_valid); end
    $display("halt redirects: ima=%0h halted=%0b", bus.IMA, bus.halted);
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd10;
    step();
    bus.redirect_pc    = 32'd12;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd12) begin bad++; $display("FAIL b2b_ima got=%0h want=c", bus.IMA); end
    step();
    total++; if (bus.out_pc !== 32'd12) begin bad++; $display("FAIL b2b_pc got=%0h want=c", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h1000_000C) begin bad++; $display("FAIL b2b_inst got=%0h want=1000000c", bus.out_inst); end
    $display("back_to_back: pc=%0h", bus.out_pc);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    step();
    total++; if (bus.IMA !== 32'd14) begin bad++; $display("FAIL rm_full_ima got=%0h want=e", bus.IMA); end
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd7;
    bus.out_ready      = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.IMA !== 32'd0) begin bad++; $display("FAIL rm_ima got=%0h want=0", bus.IMA); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rm_halted got=%0b want=0", bus.halted); end
    total++; if (bus.out_pc !== 32'd0) begin bad++; $display("FAIL rm_pc got=%0h want=0", bus.out_pc); end
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_restart_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_pc !== 32'd0) begin bad++; $display("FAIL rm_restart_pc got=%0h want=0", bus.out_pc); end
    $display("reset_mid: restart pc=%0h", bus.out_pc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_redirect();
    test_halt_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
